// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants and FSM state encoding for the UART receive framer.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state, 8E1).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;
  // Tick count at which a bit is sampled (centre of a 16-tick bit period).
  localparam logic [3:0]  UART_MID_TICK   = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider that emits a one-cycle tick every DIVISOR clocks.
// A synchronous clear holds the divider at zero so the tick phase can be
// restarted exactly on a start edge.
// Ports:
//   i_clk   - system clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   i_clr   - synchronous clear (held: no ticks)
//   o_tick  - registered one-cycle tick
// ---------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int unsigned DIVISOR = 325
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
// UART receive framer: 16x oversampled, 8N1 (or 8E1 with UART_RX_PARITY_EN
// defined). Each good byte is presented on RxData with a one-cycle RxValid;
// bad frames raise RxFrameErr or RxParityErr instead.
// Ports:
//   Clk         - system clock, rising edge
//   Rst_n       - asynchronous active-low reset
//   Rx          - raw serial line, idle high, asynchronous to Clk
//   RxData      - last good byte, held until the next good frame
//   RxValid     - one-cycle pulse, RxData new in the same cycle
//   RxFrameErr  - one-cycle pulse, stop bit sampled low
//   RxParityErr - one-cycle pulse, parity mismatch (0 when compiled out)
//   RxBusy      - high from start-edge detection until return to IDLE
// ---------------------------------------------------------------------------
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Rx,
  output logic [UART_DATA_W-1:0] RxData,
  output logic                   RxValid,
  output logic                   RxFrameErr,
  output logic                   RxParityErr,
  output logic                   RxBusy
);

  localparam int unsigned DIVISOR = CLK_FREQ / (BAUD * OVERSAMPLE);

  logic r_sync1, r_sync2, r_sync_d;
  logic w_fall, w_tick, w_tick_clr, w_mid;

  uart_state_t                          r_state;
  logic [$clog2(UART_OVERSAMPLE)-1:0]   r_tick_cnt;
  logic [2:0]                           r_bit_cnt;
  logic [UART_DATA_W-1:0]               r_shift;
  logic [UART_DATA_W-1:0]               r_data;
  logic                                 r_valid, r_ferr, r_busy;
`ifdef UART_RX_PARITY_EN
  logic                                 r_par_err, r_perr;
`endif

  // Two-flop synchronizer plus one delay stage for edge detection; all
  // reset to the idle-high level so reset release never looks like a start.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= Rx;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_fall     = r_sync_d & ~r_sync2;
  assign w_tick_clr = (r_state == ST_IDLE);
  assign w_mid      = w_tick && (r_tick_cnt == UART_MID_TICK);

  uart_baud_tick #(.DIVISOR(DIVISOR)) u_baud_tick (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_clr   (w_tick_clr),
    .o_tick  (w_tick)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err  <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
      if (w_tick) r_tick_cnt <= r_tick_cnt + 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_tick_cnt <= '0;
          if (w_fall) begin
            r_state   <= ST_START;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_err <= 1'b0;
`endif
          end
        end
        ST_START: begin
          if (w_mid) begin
            if (r_sync2) begin
              r_state <= ST_IDLE;   // glitch: line back high at mid-bit
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_mid) begin
            r_shift   <= {r_sync2, r_shift[UART_DATA_W-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_mid) begin
            if (r_sync2 != ^r_shift) r_par_err <= 1'b1;
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // Leave at the mid-stop sample so a following start edge that
          // arrives right after a single stop bit is still caught.
          if (w_mid) begin
            if (!r_sync2) begin
              r_ferr  <= 1'b1;
              r_state <= ST_WAIT_IDLE;
            end
`ifdef UART_RX_PARITY_EN
            else if (r_par_err) begin
              r_perr  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
`endif
            else begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (r_sync2) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign RxData     = r_data;
  assign RxValid    = r_valid;
  assign RxFrameErr = r_ferr;
  assign RxBusy     = r_busy;
`ifdef UART_RX_PARITY_EN
  assign RxParityErr = r_perr;
`else
  assign RxParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
// Directed bench for uart_rx_frame. The clock is scaled so one tick is 4
// clocks (one bit = 64 clocks = 640 time units) to keep frames short.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

  localparam int unsigned BAUD     = 9600;
  localparam int unsigned CLK_FREQ = BAUD * 16 * 4;
  localparam int BT      = 640;  // nominal bit time
  localparam int BT_SLOW = 653;  // driver ~2% slow
  localparam int BT_FAST = 627;  // driver ~2% fast

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Rx;
  logic [7:0] RxData;
  logic       RxValid, RxFrameErr, RxParityErr, RxBusy;

  always #5 Clk = ~Clk;

  uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Rx          (Rx),
    .RxData      (RxData),
    .RxValid     (RxValid),
    .RxFrameErr  (RxFrameErr),
    .RxParityErr (RxParityErr),
    .RxBusy      (RxBusy)
  );

  // Strobe monitor: counts high cycles of each strobe and overlaps.
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_multi = 0;
  always @(negedge Clk) begin
    if (RxValid)     n_valid = n_valid + 1;
    if (RxFrameErr)  n_ferr  = n_ferr + 1;
    if (RxParityErr) n_perr  = n_perr + 1;
    if ((int'(RxValid) + int'(RxFrameErr) + int'(RxParityErr)) > 1) n_multi = n_multi + 1;
  end

  int n_vec = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one frame LSB first; a bad stop bit extends into a 2-bit break.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_bad,
                            input int bt, input int gap_bits);
    Rx = 1'b0; #(bt);
    for (int i = 0; i < 8; i++) begin
      Rx = d[i]; #(bt);
    end
`ifdef UART_RX_PARITY_EN
    Rx = (^d) ^ par_bad; #(bt);
`else
    if (par_bad) $display("note: parity bit not sent in 8N1 build");
`endif
    if (stop_ok) begin
      Rx = 1'b1; #(bt);
    end else begin
      Rx = 1'b0; #(3 * bt);
      Rx = 1'b1;
    end
    #(gap_bits * bt);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         par_bad;
    int         bt;
    int         gap;
    int         exp_valid;
    int         exp_ferr;
    int         exp_perr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sv, sf, sp;

    //            data   stop  pbad  bt       gap  v  f  p  exp_data
    tbl.push_back('{8'h3C, 1'b1, 1'b0, BT,      2,   1, 0, 0, 8'h3C});
    tbl.push_back('{8'hA5, 1'b1, 1'b0, BT,      2,   1, 0, 0, 8'hA5});
    tbl.push_back('{8'h55, 1'b0, 1'b0, BT,      2,   0, 1, 0, 8'hA5});
    tbl.push_back('{8'h12, 1'b1, 1'b0, BT,      2,   1, 0, 0, 8'h12});
    tbl.push_back('{8'h00, 1'b1, 1'b0, BT,      0,   1, 0, 0, 8'h00});
    tbl.push_back('{8'hFF, 1'b1, 1'b0, BT,      2,   1, 0, 0, 8'hFF});
    tbl.push_back('{8'h5A, 1'b1, 1'b0, BT_SLOW, 2,   1, 0, 0, 8'h5A});
    tbl.push_back('{8'hC3, 1'b1, 1'b0, BT_FAST, 0,   1, 0, 0, 8'hC3});
    tbl.push_back('{8'h96, 1'b1, 1'b0, BT_FAST, 2,   1, 0, 0, 8'h96});
`ifdef UART_RX_PARITY_EN
    tbl.push_back('{8'h07, 1'b1, 1'b1, BT,      2,   0, 0, 1, 8'h96});
    tbl.push_back('{8'h07, 1'b1, 1'b0, BT,      2,   1, 0, 0, 8'h07});
`endif

    // Reset state
    Rst_n = 1'b0;
    Rx    = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_data",   {24'b0, RxData}, 32'h00);
    check("rst_valid",  {31'b0, RxValid}, 0);
    check("rst_ferr",   {31'b0, RxFrameErr}, 0);
    check("rst_perr",   {31'b0, RxParityErr}, 0);
    check("rst_busy",   {31'b0, RxBusy}, 0);
    Rst_n = 1'b1;
    repeat (5) @(negedge Clk);

    // Start-edge latency and a 4-tick glitch (16 clocks low)
    sv = n_valid; sf = n_ferr; sp = n_perr;
    Rx = 1'b0;
    @(negedge Clk);
    check("busy_not_yet", {31'b0, RxBusy}, 0);
    repeat (2) @(negedge Clk);
    check("busy_after_edge", {31'b0, RxBusy}, 1);
    repeat (13) @(negedge Clk);
    Rx = 1'b1;
    #(BT);
    @(negedge Clk);
    check("glitch_busy",  {31'b0, RxBusy}, 0);
    check("glitch_valid", n_valid - sv, 0);
    check("glitch_ferr",  n_ferr - sf, 0);
    check("glitch_perr",  n_perr - sp, 0);

    // Table-driven frames
    foreach (tbl[k]) begin
      sv = n_valid; sf = n_ferr; sp = n_perr;
      send_frame(tbl[k].data, tbl[k].stop_ok, tbl[k].par_bad, tbl[k].bt, tbl[k].gap);
      @(negedge Clk);
      check($sformatf("v%0d_valid", k), n_valid - sv, tbl[k].exp_valid);
      check($sformatf("v%0d_ferr", k),  n_ferr - sf,  tbl[k].exp_ferr);
      check($sformatf("v%0d_perr", k),  n_perr - sp,  tbl[k].exp_perr);
      check($sformatf("v%0d_data", k),  {24'b0, RxData}, {24'b0, tbl[k].exp_data});
      check($sformatf("v%0d_busy", k),  {31'b0, RxBusy}, 0);
    end

    // Reset asserted during data bit 4 of 0xFF
    sv = n_valid; sf = n_ferr; sp = n_perr;
    Rx = 1'b0; #(BT);
    for (int i = 0; i < 4; i++) begin
      Rx = 1'b1; #(BT);
    end
    #(BT / 2);
    check("midrst_busy_before", {31'b0, RxBusy}, 1);
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    check("midrst_data", {24'b0, RxData}, 32'h00);
    check("midrst_busy", {31'b0, RxBusy}, 0);
    Rst_n = 1'b1;
    #(6 * BT);
    @(negedge Clk);
    check("midrst_no_strobe", (n_valid - sv) + (n_ferr - sf) + (n_perr - sp), 0);
    sv = n_valid;
    send_frame(8'h81, 1'b1, 1'b0, BT, 2);
    @(negedge Clk);
    check("after_rst_valid", n_valid - sv, 1);
    check("after_rst_data", {24'b0, RxData}, 32'h81);

    check("strobe_overlap", n_multi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
